lfsr_gen: RTL and testbench

Parametrised pseudo-random sequence generator. It replaces the fixed 8-bit Fibonacci LFSR used as the stimulus and operand source for the pipelined multiplier datapath. It adds generic width and taps, and run-time Fibonacci/Galois mode selection. It also adds seed load, gated stepping, multiple steps per clock, all-zero lockup recovery, and sequence-wrap/period reporting for self-check.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/lfsr_step.sv | 24 ++
 rtl/lfsr_gen.sv | 80 ++++++++
 tb/tb_lfsr_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
// The tap masks are in Fibonacci form; galois_mask() derives the Galois feedback mask from them.
package lfsr_pkg;

   localparam logic LFSR_FIB = 1'b0;
   localparam logic LFSR_GAL = 1'b1;

   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [31:0] TAPS_W32 = 32'hA3000000;

   // Galois mask is the Fibonacci taps shifted up one place, with bit 0 forced
   // to 1 (the x^0 term). Bits at or above the width are cleared.
   function automatic logic [31:0] galois_mask(input logic [31:0] taps, input int width);
      logic [31:0] m;
      m = 32'd1;
      for (int i = 1; i < 32; i++) begin
         if (i < width) m[i] = taps[i-1];
      end
      return m;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step, either Fibonacci or Galois as selected by mode.
// lfsr_gen chains several of these to take more than one step per clock.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W8
) (
   input  logic [WIDTH-1:0] state,
   input  logic             mode,
   output logic [WIDTH-1:0] next
);

   localparam logic [31:0]      GMASK_FULL = galois_mask(32'(TAPS), WIDTH);
   localparam logic [WIDTH-1:0] GMASK      = GMASK_FULL[WIDTH-1:0];

   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;

   assign fib_next = {state[WIDTH-2:0], ^(state & TAPS)};
   assign gal_next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & GMASK);
   assign next     = (mode == LFSR_GAL) ? gal_next : fib_next;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with seed load, multiple steps per clock and all-zero lockup recovery.
// Also reports when the sequence returns to the loaded reference state, and how many enabled cycles that took.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_W8,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter int               STEPS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mode,
   output logic [WIDTH-1:0] lfsr,
   output logic             wrap,
   output logic             lockup,
   output logic [WIDTH-1:0] period
);

   logic [WIDTH-1:0] chain [STEPS+1];
   logic [WIDTH-1:0] step_out;
   logic [WIDTH-1:0] ref_state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_inc;

   assign chain[0] = lfsr;

   for (genvar g = 0; g < STEPS; g++) begin : g_step
      lfsr_step #(
         .WIDTH (WIDTH),
         .TAPS  (TAPS)
      ) u_step (
         .state (chain[g]),
         .mode  (mode),
         .next  (chain[g+1])
      );
   end

   assign step_out = chain[STEPS];
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr      <= SEED;
         ref_state <= SEED;
         cnt       <= '0;
         period    <= '0;
         wrap      <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         wrap   <= 1'b0;
         lockup <= 1'b0;
         if (load) begin
            // A zero seed would lock the register up, so SEED is substituted and the swap is flagged.
            if (seed_in == '0) begin
               lfsr      <= SEED;
               ref_state <= SEED;
               lockup    <= 1'b1;
            end else begin
               lfsr      <= seed_in;
               ref_state <= seed_in;
            end
            cnt <= '0;
         end else if (en) begin
            lfsr <= step_out;
            if (step_out == ref_state) begin
               wrap   <= 1'b1;
               period <= cnt_inc;
               cnt    <= '0;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen (8-bit default build plus an 8-steps-per-clock build).
// Expected outputs come from an independent behavioural model queued at drive time.
module tb_lfsr_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [7:0] seed_in = 8'h00;
   logic       mode = 1'b0;
   logic [7:0] lfsr;
   logic       wrap;
   logic       lockup;
   logic [7:0] period;
   logic [7:0] lfsr8;
   logic       wrap8;
   logic       lockup8;
   logic [7:0] period8;

   typedef struct packed {
      logic [7:0] lfsr;
      logic       wrap;
      logic       lockup;
      logic [7:0] period;
   } exp_t;

   exp_t sb[$];

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0] m_lfsr, m_ref, m_cnt, m_period;

   always #5 clk = ~clk;

   lfsr_gen u_dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .seed_in (seed_in),
      .mode    (mode),
      .lfsr    (lfsr),
      .wrap    (wrap),
      .lockup  (lockup),
      .period  (period)
   );

   lfsr_gen #(.STEPS(8)) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .seed_in (seed_in),
      .mode    (mode),
      .lfsr    (lfsr8),
      .wrap    (wrap8),
      .lockup  (lockup8),
      .period  (period8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] fib_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [7:0] gal_step(input logic [7:0] s);
      return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
   endfunction

   task automatic model(input logic r, input logic e, input logic l,
                        input logic [7:0] s, input logic m, output exp_t x);
      logic [7:0] nxt;
      x.wrap   = 1'b0;
      x.lockup = 1'b0;
      if (r) begin
         m_lfsr = 8'h01; m_ref = 8'h01; m_cnt = 8'h00; m_period = 8'h00;
      end else if (l) begin
         if (s == 8'h00) begin
            m_lfsr = 8'h01; x.lockup = 1'b1;
         end else begin
            m_lfsr = s;
         end
         m_ref = m_lfsr;
         m_cnt = 8'h00;
      end else if (e) begin
         nxt = m ? gal_step(m_lfsr) : fib_step(m_lfsr);
         m_lfsr = nxt;
         m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'h01;
         if (nxt == m_ref) begin
            x.wrap = 1'b1;
            m_period = m_cnt;
            m_cnt = 8'h00;
         end
      end
      x.lfsr   = m_lfsr;
      x.period = m_period;
   endtask

   task automatic cycle(input logic r, input logic e, input logic l,
                        input logic [7:0] s, input logic m);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; load = l; seed_in = s; mode = m;
      model(r, e, l, s, m, x);
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("lfsr", lfsr, x.lfsr);
      chk("wrap", wrap, x.wrap);
      chk("lockup", lockup, x.lockup);
      chk("period", period, x.period);
      chk("nonzero", lfsr == 8'h00, 1'b0);
   endtask

   logic [7:0] t1_seq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
   logic [7:0] t2_seq [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71};

   initial begin
      int wraps;
      logic r, e, l, m;
      logic [7:0] s;

      // Fibonacci from reset, then complete the first period.
      cycle(1, 0, 0, 8'h00, 0);
      chk("rst_lfsr", lfsr, 8'h01);
      chk("rst_period", period, 8'h00);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst8_lfsr", lfsr8, 8'h01);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 0, 8'h00, 0);
         chk("t1_seq", lfsr, t1_seq[i]);
         if (i == 0) chk("steps8", lfsr8, 8'h1C);
      end
      wraps = 0;
      for (int i = 4; i < 255; i++) begin
         cycle(0, 1, 0, 8'h00, 0);
         if (wrap) wraps++;
      end
      chk("t1_wrap_at_255", wrap, 1'b1);
      chk("t1_wraps", wraps, 1);
      chk("t1_period", period, 8'd255);

      // Galois from reset.
      cycle(1, 0, 0, 8'h00, 1);
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 0, 8'h00, 1);
         chk("t2_seq", lfsr, t2_seq[i]);
      end
      for (int i = 8; i < 255; i++) cycle(0, 1, 0, 8'h00, 1);
      chk("t2_period", period, 8'd255);
      chk("t2_wrap", wrap, 1'b1);

      // Zero seed is replaced by SEED with a one-cycle lockup pulse.
      cycle(0, 1, 0, 8'h00, 0);
      cycle(0, 0, 1, 8'h00, 0);
      chk("t3_lfsr", lfsr, 8'h01);
      chk("t3_lockup", lockup, 1'b1);
      chk("t3_period_kept", period, 8'd255);
      cycle(0, 0, 0, 8'h00, 0);
      chk("t3_lockup_clear", lockup, 1'b0);
      cycle(0, 1, 1, 8'hA5, 0);
      chk("t3_seed", lfsr, 8'hA5);
      chk("t3_no_lockup", lockup, 1'b0);
      for (int i = 0; i < 255; i++) cycle(0, 1, 0, 8'h00, 0);
      chk("t3_reseed_wrap", lfsr, 8'hA5);
      chk("t3_reseed_period", period, 8'd255);

      // Reset mid-run wins over load and en.
      cycle(0, 0, 1, 8'h01, 0);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 8'h00, 0);
      chk("t5_mid", lfsr, 8'h47);
      cycle(1, 1, 1, 8'h33, 0);
      chk("t5_lfsr", lfsr, 8'h01);
      chk("t5_period", period, 8'h00);
      chk("t5_wrap", wrap, 1'b0);
      cycle(0, 1, 0, 8'h00, 0);
      chk("t5_restart", lfsr, 8'h02);

      // Random enable gating with occasional loads, mode flips and resets.
      m = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         e = $urandom_range(0, 3) != 0;
         l = $urandom_range(0, 60) == 0;
         r = $urandom_range(0, 300) == 0;
         s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 99) == 0) m = ~m;
         cycle(r, e, l, s, m);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
